input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 136 +++++++++++++
 tb/tb_input_conditioner.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Two-flop synchronizes 4 buttons and 16 switches, debounces them on a sample tick and emits edge pulses.
// Optional macro INPUT_CONDITIONER_LOCKOUT_EN suppresses switch pulses for 2*STABLE_SAMPLES ticks after any switch pulse.
module input_conditioner #(
  parameter int CLK_HZ         = 100000000,
  parameter int SAMPLE_HZ      = 1000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [3:0]  buttons_i,
  input  logic [15:0] switches_i,
  output logic [3:0]  buttons_o,
  output logic [15:0] switches_o,
  output logic [3:0]  button_press_o,
  output logic [15:0] switch_toggle_o,
  output logic        ready_o
);
  localparam int NCH   = 20;
  localparam int DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [3:0] STABLE_LAST = 4'(STABLE_SAMPLES - 1);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [NCH-1:0]      raw;
  logic [NCH-1:0]      meta_q, sync_q;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                tick;
  logic [0:0]          state_q, state_d;
  logic [3:0]          init_cnt_q, init_cnt_d;
  logic [NCH-1:0][3:0] ch_cnt_q, ch_cnt_d;
  logic [NCH-1:0]      level_q, level_d;
  logic [NCH-1:0]      flip;
  logic [3:0]          press_q, press_d;
  logic [15:0]         toggle_q, toggle_d;
  logic                sw_pulse_ok;

  assign raw  = {switches_i, buttons_i};
  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Per-channel stability counters; only run once the initial snapshot is taken.
  always_comb begin
    ch_cnt_d = ch_cnt_q;
    flip     = '0;
    if (tick && state_q == ST_RUN) begin
      for (int i = 0; i < NCH; i++) begin
        if (sync_q[i] != level_q[i]) begin
          if (ch_cnt_q[i] == STABLE_LAST) begin
            flip[i]     = 1'b1;
            ch_cnt_d[i] = '0;
          end else begin
            ch_cnt_d[i] = ch_cnt_q[i] + 4'd1;
          end
        end else begin
          ch_cnt_d[i] = '0;
        end
      end
    end
  end

`ifdef INPUT_CONDITIONER_LOCKOUT_EN
  localparam logic [4:0] LOCK_TICKS = 5'(2 * STABLE_SAMPLES);
  logic [4:0] lock_q, lock_d;

  assign sw_pulse_ok = (lock_q == '0);

  // Window is armed only by a pulse that actually went out, so suppressed edges never extend it.
  always_comb begin
    lock_d = lock_q;
    if (tick && state_q == ST_RUN) begin
      if (sw_pulse_ok && (|flip[19:4])) lock_d = LOCK_TICKS;
      else if (!sw_pulse_ok)            lock_d = lock_q - 5'd1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) lock_q <= '0;
    else          lock_q <= lock_d;
  end
`else
  assign sw_pulse_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    level_d    = level_q ^ flip;
    press_d    = flip[3:0] & sync_q[3:0];
    toggle_d   = sw_pulse_ok ? flip[19:4] : '0;
    if (tick && state_q == ST_INIT) begin
      level_d = sync_q;
      if (init_cnt_q == STABLE_LAST) begin
        state_d    = ST_RUN;
        init_cnt_d = '0;
      end else begin
        init_cnt_d = init_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      meta_q     <= '0;
      sync_q     <= '0;
      div_q      <= '0;
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ch_cnt_q   <= '0;
      level_q    <= '0;
      press_q    <= '0;
      toggle_q   <= '0;
    end else begin
      meta_q     <= raw;
      sync_q     <= meta_q;
      div_q      <= div_d;
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ch_cnt_q   <= ch_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      toggle_q   <= toggle_d;
    end
  end

  assign buttons_o       = level_q[3:0];
  assign switches_o      = level_q[19:4];
  assign button_press_o  = press_q;
  assign switch_toggle_o = toggle_q;
  assign ready_o         = (state_q == ST_RUN);

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: vector table for steady levels, pulse scoreboard, timed corner sequences.
module tb_input_conditioner;
  logic        clock_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [3:0]  buttons_i = '0;
  logic [15:0] switches_i = '0;
  logic [3:0]  buttons_o;
  logic [15:0] switches_o;
  logic [3:0]  button_press_o;
  logic [15:0] switch_toggle_o;
  logic        ready_o;

  input_conditioner #(.CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_SAMPLES(3)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .buttons_i(buttons_i), .switches_i(switches_i),
    .buttons_o(buttons_o), .switches_o(switches_o), .button_press_o(button_press_o),
    .switch_toggle_o(switch_toggle_o), .ready_o(ready_o)
  );

  always #5 clock_i = ~clock_i;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ecnt    = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;

  typedef struct {
    logic [3:0]  btn;
    logic [15:0] sw;
    logic [3:0]  exp_btn;
    logic [15:0] exp_sw;
    logic [3:0]  exp_press;
    logic [15:0] exp_tog;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock_i);
      ecnt++;
    end
    #1;
  endtask

  // Leaves time just after an edge whose index is one past a sample tick.
  task automatic align();
    while (ecnt % 10 != 1) step(1);
  endtask

  always @(negedge clock_i) begin
    if (reset_i && ((button_press_o != '0) || (switch_toggle_o != '0))) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got press=%0h toggle=%0h expected none",
                 button_press_o, switch_toggle_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse", {44'h0, button_press_o, switch_toggle_o}, {44'h0, mon_e});
      end
    end
  end

  initial begin
    vecs[0] = '{4'h1, 16'h0005, 4'h1, 16'h0005, 4'h1, 16'h0000};
    vecs[1] = '{4'h1, 16'h00F5, 4'h1, 16'h00F5, 4'h0, 16'h00F0};
    vecs[2] = '{4'h0, 16'h00F0, 4'h0, 16'h00F0, 4'h0, 16'h0005};
    vecs[3] = '{4'hA, 16'hA5F0, 4'hA, 16'hA5F0, 4'hA, 16'hA500};
    vecs[4] = '{4'hA, 16'h0000, 4'hA, 16'h0000, 4'h0, 16'hA5F0};
    vecs[5] = '{4'h0, 16'hFFFF, 4'h0, 16'hFFFF, 4'h0, 16'hFFFF};
    vecs[6] = '{4'h0, 16'h0000, 4'h0, 16'h0000, 4'h0, 16'hFFFF};

    // Power-up snapshot with switches 0 and 2 held.
    switches_i = 16'h0005;
    #23;
    check("reset_outputs", {23'h0, ready_o, buttons_o, switches_o, button_press_o, switch_toggle_o}, 64'h0);
    reset_i = 1'b1;
    ecnt = 0;
    step(29);
    check("ready_before_3_ticks", ready_o, 0);
    step(1);
    check("ready_after_3_ticks", ready_o, 1);
    check("init_switches", switches_o, 16'h0005);
    check("init_buttons", buttons_o, 4'h0);

    for (int i = 0; i < 7; i++) begin
      buttons_i  = vecs[i].btn;
      switches_i = vecs[i].sw;
      if ((vecs[i].exp_press != '0) || (vecs[i].exp_tog != '0))
        exp_q.push_back({vecs[i].exp_press, vecs[i].exp_tog});
      step(100);
      check("vec_buttons", buttons_o, vecs[i].exp_btn);
      check("vec_switches", switches_o, vecs[i].exp_sw);
      check("vec_pulses_drained", exp_q.size(), 0);
    end

    // Button 2 press: exact latency and single-cycle pulse, then silent release.
    align();
    buttons_i = 4'b0100;
    exp_q.push_back({4'b0100, 16'h0});
    step(28);
    check("btn2_before_tick3", buttons_o, 4'h0);
    step(1);
    check("btn2_level", buttons_o, 4'b0100);
    check("btn2_press", button_press_o, 4'b0100);
    step(1);
    check("btn2_press_one_cycle", button_press_o, 4'h0);
    buttons_i = 4'b0000;
    step(60);
    check("btn2_release_level", buttons_o, 4'h0);

    // Switch 7 glitch lasting two ticks.
    align();
    switches_i = 16'h0080;
    step(20);
    switches_i = 16'h0000;
    step(10);
    check("glitch_level_mid", switches_o, 16'h0000);
    step(50);
    check("glitch_level_end", switches_o, 16'h0000);

    // Switches 0 and 15 flip together.
    align();
    switches_i = 16'h8001;
    exp_q.push_back({4'h0, 16'h8001});
    step(28);
    check("dual_before", switch_toggle_o, 16'h0000);
    step(1);
    check("dual_toggle", switch_toggle_o, 16'h8001);
    check("dual_level", switches_o, 16'h8001);
    step(1);
    check("dual_toggle_one_cycle", switch_toggle_o, 16'h0000);

    // Switch 3 then switch 4 two ticks later.
    step(100);
    align();
    switches_i = 16'h8009;
    exp_q.push_back({4'h0, 16'h0008});
    step(20);
    switches_i = 16'h8019;
`ifndef INPUT_CONDITIONER_LOCKOUT_EN
    exp_q.push_back({4'h0, 16'h0010});
`endif
    step(60);
    check("lockout_levels", switches_o, 16'h8019);
    check("lockout_pulses_drained", exp_q.size(), 0);

    // Reset in the middle of a debounce, inputs held through re-init.
    step(100);
    align();
    switches_i = 16'h8219;
    buttons_i  = 4'b0001;
    step(15);
    #2;
    reset_i = 1'b0;
    #1;
    check("midreset_outputs", {23'h0, ready_o, buttons_o, switches_o, button_press_o, switch_toggle_o}, 64'h0);
    step(3);
    check("midreset_held", {23'h0, ready_o, buttons_o, switches_o, button_press_o, switch_toggle_o}, 64'h0);
    reset_i = 1'b1;
    ecnt = 0;
    step(29);
    check("reinit_not_ready", ready_o, 0);
    step(1);
    check("reinit_ready", ready_o, 1);
    check("reinit_switches", switches_o, 16'h8219);
    check("reinit_buttons", buttons_o, 4'h1);
    step(20);
    check("final_pulses_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
